// File: rtl/rom_fetch_arbiter_pkg.sv
// Shared processor package: fetch FSM state encoding, the RV32 opcode/funct3
// fields used to build the canonical NOP, and a byte-to-word address helper.
package rom_fetch_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } fetch_state_e;

    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [2:0] F3_ADDI    = 3'b000;

    // ADDI x0,x0,0
    localparam logic [31:0] NOP_WORD_DEFAULT = {12'h000, 5'd0, F3_ADDI, 5'd0, OPC_OP_IMM};

    function automatic logic [29:0] word_index(input logic [31:0] byte_addr);
        return 30'(byte_addr >> 2);
    endfunction

endpackage

// File: rtl/rom_fetch_arbiter_rr_select.sv
// Combinational round-robin picker.
//   req     : per-requester request bits
//   ptr     : index where the search starts (wraps N-1 -> 0)
//   grant   : index of the first high req found from ptr
//   any_req : at least one req bit is high
module rr_select #(
    parameter int N    = 4,
    parameter int IDXW = 2
) (
    input  logic [N-1:0]    req,
    input  logic [IDXW-1:0] ptr,
    output logic [IDXW-1:0] grant,
    output logic            any_req
);

    int idx;

    // Walk offsets from farthest to nearest so the nearest high req wins.
    always_comb begin
        grant   = '0;
        any_req = |req;
        idx     = 0;
        for (int k = N - 1; k >= 0; k--) begin
            idx = int'(ptr) + k;
            if (idx >= N) idx = idx - N;
            if (req[IDXW'(idx)]) grant = IDXW'(idx);
        end
    end

endmodule

// File: rtl/rom_fetch_arbiter.sv
// Arbitrates N_CORES instruction fetchers onto one program ROM port.
// One fetch takes three cycles (IDLE -> ISSUE -> RESP); out-of-range word
// indices return NOP_WORD and pulse oob_err alongside ack.
//   clk, reset       : system clock, async active-low reset
//   req, addr        : per-core request and byte address (32 bits per core)
//   ack, rdata       : one-hot response pulse and shared instruction word
//   rom_addr/rom_data: registered word-aligned ROM address, combinational data
//   oob_err          : out-of-range pulse, fetch_cnt: saturating fetch count
//
// state    | meaning
// ST_IDLE  | waiting for any req; latches grant and rom_addr
// ST_ISSUE | ROM data valid for rom_addr; registers rdata, ack, oob_err
// ST_RESP  | ack visible; advances ptr and fetch_cnt on exit
module rom_fetch_arbiter
    import rom_fetch_arbiter_pkg::*;
#(
    parameter int          N_CORES   = 4,
    parameter int          ROM_WORDS = 38,
    parameter logic [31:0] NOP_WORD  = NOP_WORD_DEFAULT
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N_CORES-1:0]   req,
    input  logic [32*N_CORES-1:0] addr,
    output logic [N_CORES-1:0]   ack,
    output logic [31:0]          rdata,
    output logic [31:0]          rom_addr,
    input  logic [31:0]          rom_data,
    output logic                 oob_err,
    output logic [15:0]          fetch_cnt
);

    localparam int IDXW = (N_CORES > 1) ? $clog2(N_CORES) : 1;

    // Reset asserts immediately but releases only after two clk edges.
    logic rst_meta_q, rst_sync_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rst_meta_q <= 1'b0;
            rst_sync_q <= 1'b0;
        end else begin
            rst_meta_q <= 1'b1;
            rst_sync_q <= rst_meta_q;
        end
    end

    fetch_state_e        state_q, state_d;
    logic [IDXW-1:0]     grant_q, grant_d;
    logic [IDXW-1:0]     ptr_q, ptr_d;
    logic [31:0]         rom_addr_q, rom_addr_d;
    logic [31:0]         rdata_q, rdata_d;
    logic [N_CORES-1:0]  ack_q, ack_d;
    logic                oob_q, oob_d;
    logic [15:0]         fetch_cnt_q, fetch_cnt_d;

    logic [IDXW-1:0]     sel_idx;
    logic                any_req;
    logic [31:0]         addr_arr [N_CORES];

    for (genvar g = 0; g < N_CORES; g++) begin : g_addr
        assign addr_arr[g] = addr[32*g +: 32];
    end

    rr_select #(.N(N_CORES), .IDXW(IDXW)) u_rr (
        .req     (req),
        .ptr     (ptr_q),
        .grant   (sel_idx),
        .any_req (any_req)
    );

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        ptr_d       = ptr_q;
        rom_addr_d  = rom_addr_q;
        rdata_d     = rdata_q;
        ack_d       = ack_q;
        oob_d       = oob_q;
        fetch_cnt_d = fetch_cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (any_req) begin
                    grant_d    = sel_idx;
                    rom_addr_d = addr_arr[sel_idx] & 32'hFFFF_FFFC;
                    state_d    = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if ({2'b00, word_index(rom_addr_q)} < 32'(ROM_WORDS)) begin
                    rdata_d = rom_data;
                    oob_d   = 1'b0;
                end else begin
                    rdata_d = NOP_WORD;
                    oob_d   = 1'b1;
                end
                ack_d          = '0;
                ack_d[grant_q] = 1'b1;
                state_d        = ST_RESP;
            end
            ST_RESP: begin
                ack_d   = '0;
                oob_d   = 1'b0;
                ptr_d   = (grant_q == IDXW'(N_CORES - 1)) ? '0 : grant_q + IDXW'(1);
                if (fetch_cnt_q != 16'hFFFF) fetch_cnt_d = fetch_cnt_q + 16'd1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_sync_q) begin
        if (!rst_sync_q) begin
            state_q     <= ST_IDLE;
            grant_q     <= '0;
            ptr_q       <= '0;
            rom_addr_q  <= '0;
            rdata_q     <= '0;
            ack_q       <= '0;
            oob_q       <= 1'b0;
            fetch_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            ptr_q       <= ptr_d;
            rom_addr_q  <= rom_addr_d;
            rdata_q     <= rdata_d;
            ack_q       <= ack_d;
            oob_q       <= oob_d;
            fetch_cnt_q <= fetch_cnt_d;
        end
    end

    assign ack       = ack_q;
    assign rdata     = rdata_q;
    assign rom_addr  = rom_addr_q;
    assign oob_err   = oob_q;
    assign fetch_cnt = fetch_cnt_q;

endmodule

// File: tb/tb_rom_fetch_arbiter.sv
module tb_rom_fetch_arbiter;

    logic         clk = 1'b0;
    logic         reset;
    logic [3:0]   req;
    logic [127:0] addr;
    logic [3:0]   ack;
    logic [31:0]  rdata;
    logic [31:0]  rom_addr;
    logic [31:0]  rom_data;
    logic         oob_err;
    logic [15:0]  fetch_cnt;

    integer checks   = 0;
    integer failures = 0;
    logic [15:0] exp_cnt;

    always #5 clk = ~clk;

    rom_fetch_arbiter #(.N_CORES(4), .ROM_WORDS(38), .NOP_WORD(32'h00000013)) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .addr      (addr),
        .ack       (ack),
        .rdata     (rdata),
        .rom_addr  (rom_addr),
        .rom_data  (rom_data),
        .oob_err   (oob_err),
        .fetch_cnt (fetch_cnt)
    );

    // ROM model: word 4 is the known instruction, others are tagged by index,
    // anything past the end reads as garbage so NOP substitution is visible.
    function automatic logic [31:0] rom_word(input logic [31:0] ba);
        logic [29:0] i;
        i = ba[31:2];
        if (i < 30'd38) begin
            if (i == 30'd4) return 32'h00002083;
            return 32'hA500_0000 | {2'b00, i};
        end
        return 32'hDEAD_BEEF;
    endfunction

    assign rom_data = rom_word(rom_addr);

    task automatic wait_ack(input int budget, output logic [3:0] a, output bit timed_out);
        timed_out = 1'b1;
        a = 4'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (ack !== 4'b0) begin
                a = ack;
                timed_out = 1'b0;
                break;
            end
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b0;
        req   = 4'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        exp_cnt = 16'd0;
    endtask

    task automatic do_fetch(input int core, input logic [31:0] a,
                            input logic [31:0] exp_data, input logic exp_oob);
        logic [3:0] got;
        bit to;
        @(negedge clk);
        addr[32*core +: 32] = a;
        req[core] = 1'b1;
        wait_ack(12, got, to);
        checks++;
        if (to || got !== (4'b0001 << core)) begin
            failures++;
            $display("FAIL fetch_ack core=%0d got=%b timeout=%0d exp=%b", core, got, to, 4'b0001 << core);
        end
        checks++;
        if (rdata !== exp_data) begin
            failures++;
            $display("FAIL fetch_rdata core=%0d got=%h exp=%h", core, rdata, exp_data);
        end
        checks++;
        if (oob_err !== exp_oob) begin
            failures++;
            $display("FAIL fetch_oob core=%0d got=%b exp=%b", core, oob_err, exp_oob);
        end
        req[core] = 1'b0;
        @(negedge clk);
        if (exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
        checks++;
        if (fetch_cnt !== exp_cnt || ack !== 4'b0 || oob_err !== 1'b0) begin
            failures++;
            $display("FAIL fetch_after cnt=%h exp=%h ack=%b oob=%b", fetch_cnt, exp_cnt, ack, oob_err);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        req   = 4'b0;
        addr  = '0;
        #1 reset = 1'b0;
        #3;
        checks++;
        if (ack !== 4'b0 || oob_err !== 1'b0 || rdata !== 32'h0 ||
            rom_addr !== 32'h0 || fetch_cnt !== 16'h0) begin
            failures++;
            $display("FAIL reset_state ack=%b oob=%b rdata=%h rom_addr=%h cnt=%h exp all zero",
                     ack, oob_err, rdata, rom_addr, fetch_cnt);
        end
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        exp_cnt = 16'd0;
    endtask

    task automatic test_single_core();
        @(negedge clk);
        addr[31:0] = 32'h10;
        req[0] = 1'b1;
        @(negedge clk);
        checks++;
        if (ack !== 4'b0 || rom_addr !== 32'h10) begin
            failures++;
            $display("FAIL single_issue ack=%b rom_addr=%h exp ack=0000 rom_addr=00000010", ack, rom_addr);
        end
        @(negedge clk);
        checks++;
        if (ack !== 4'b0001 || rdata !== 32'h00002083) begin
            failures++;
            $display("FAIL single_ack ack=%b rdata=%h exp ack=0001 rdata=00002083", ack, rdata);
        end
        req[0] = 1'b0;
        @(negedge clk);
        exp_cnt = 16'd1;
        checks++;
        if (fetch_cnt !== 16'd1 || ack !== 4'b0) begin
            failures++;
            $display("FAIL single_cnt cnt=%h ack=%b exp cnt=0001 ack=0000", fetch_cnt, ack);
        end
    endtask

    task automatic test_misaligned();
        do_fetch(1, 32'h13, 32'h00002083, 1'b0);
        checks++;
        if (rom_addr !== 32'h10) begin
            failures++;
            $display("FAIL misaligned_rom_addr got=%h exp=00000010", rom_addr);
        end
    endtask

    task automatic test_out_of_range();
        do_fetch(2, 32'h98, 32'h00000013, 1'b1);
        do_fetch(2, 32'h94, rom_word(32'h94), 1'b0);
        repeat (3) @(negedge clk);
        checks++;
        if (rdata !== rom_word(32'h94)) begin
            failures++;
            $display("FAIL rdata_hold got=%h exp=%h", rdata, rom_word(32'h94));
        end
    endtask

    task automatic test_deassert_in_flight();
        @(negedge clk);
        addr[127:96] = 32'h08;
        req[3] = 1'b1;
        @(negedge clk);
        req[3] = 1'b0;
        @(negedge clk);
        checks++;
        if (ack !== 4'b1000 || rdata !== rom_word(32'h08)) begin
            failures++;
            $display("FAIL deassert_ack ack=%b rdata=%h exp ack=1000 rdata=%h", ack, rdata, rom_word(32'h08));
        end
        @(negedge clk);
        exp_cnt = exp_cnt + 16'd1;
        checks++;
        if (fetch_cnt !== exp_cnt) begin
            failures++;
            $display("FAIL deassert_cnt got=%h exp=%h", fetch_cnt, exp_cnt);
        end
    endtask

    task automatic test_contention();
        int order [5];
        int when  [5];
        int n;
        int exp_order [5];
        exp_order = '{0, 1, 2, 3, 0};
        apply_reset();
        for (int c = 0; c < 4; c++) addr[32*c +: 32] = 32'(c * 8 + 4);
        n = 0;
        @(negedge clk);
        req = 4'b1111;
        for (int cyc = 0; cyc < 40 && n < 5; cyc++) begin
            @(negedge clk);
            if (ack !== 4'b0) begin
                checks++;
                if (!$onehot(ack)) begin
                    failures++;
                    $display("FAIL contention_onehot ack=%b exp one bit", ack);
                end
                order[n] = 0;
                for (int b = 0; b < 4; b++) if (ack[b]) order[n] = b;
                when[n] = cyc;
                checks++;
                if (rdata !== rom_word(32'(order[n] * 8 + 4))) begin
                    failures++;
                    $display("FAIL contention_rdata core=%0d got=%h exp=%h", order[n], rdata,
                             rom_word(32'(order[n] * 8 + 4)));
                end
                n++;
                if (n == 5) req = 4'b0;
            end
        end
        checks++;
        if (n != 5) begin
            failures++;
            $display("FAIL contention_count got=%0d exp=5", n);
        end
        for (int i = 0; i < n; i++) begin
            checks++;
            if (order[i] != exp_order[i] || (i > 0 && when[i] - when[i-1] != 3)) begin
                failures++;
                $display("FAIL contention_order idx=%0d core=%0d exp=%0d gap=%0d exp_gap=3",
                         i, order[i], exp_order[i], (i > 0) ? when[i] - when[i-1] : 3);
            end
        end
        @(negedge clk);
        exp_cnt = 16'd5;
        checks++;
        if (fetch_cnt !== exp_cnt) begin
            failures++;
            $display("FAIL contention_cnt got=%h exp=%h", fetch_cnt, exp_cnt);
        end
    endtask

    task automatic test_reset_mid_fetch();
        logic [3:0] got;
        bit to;
        do_fetch(1, 32'h20, rom_word(32'h20), 1'b0);
        @(negedge clk);
        addr[63:32]  = 32'h24;
        addr[127:96] = 32'h28;
        req = 4'b1010;
        @(negedge clk);
        checks++;
        if (rom_addr !== 32'h28) begin
            failures++;
            $display("FAIL midreset_grant rom_addr=%h exp=00000028", rom_addr);
        end
        reset = 1'b0;
        #1;
        checks++;
        if (ack !== 4'b0 || oob_err !== 1'b0 || rdata !== 32'h0 ||
            rom_addr !== 32'h0 || fetch_cnt !== 16'h0) begin
            failures++;
            $display("FAIL midreset_clear ack=%b oob=%b rdata=%h rom_addr=%h cnt=%h exp all zero",
                     ack, oob_err, rdata, rom_addr, fetch_cnt);
        end
        @(negedge clk);
        checks++;
        if (ack !== 4'b0) begin
            failures++;
            $display("FAIL midreset_noack ack=%b exp=0000", ack);
        end
        @(negedge clk);
        reset = 1'b1;
        exp_cnt = 16'd0;
        wait_ack(12, got, to);
        checks++;
        if (to || got !== 4'b0010 || rdata !== rom_word(32'h24)) begin
            failures++;
            $display("FAIL midreset_first got=%b timeout=%0d rdata=%h exp ack=0010 rdata=%h",
                     got, to, rdata, rom_word(32'h24));
        end
        req = 4'b0;
        @(negedge clk);
        exp_cnt = 16'd1;
        checks++;
        if (fetch_cnt !== exp_cnt) begin
            failures++;
            $display("FAIL midreset_cnt got=%h exp=%h", fetch_cnt, exp_cnt);
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic test_saturation();
        @(negedge clk);
        force dut.fetch_cnt_q = 16'hFFFD;
        @(negedge clk);
        release dut.fetch_cnt_q;
        exp_cnt = 16'hFFFD;
        @(negedge clk);
        checks++;
        if (fetch_cnt !== 16'hFFFD) begin
            failures++;
            $display("FAIL sat_preload got=%h exp=FFFD", fetch_cnt);
        end
        do_fetch(0, 32'h10, 32'h00002083, 1'b0);
        do_fetch(0, 32'h10, 32'h00002083, 1'b0);
        do_fetch(0, 32'h10, 32'h00002083, 1'b0);
        checks++;
        if (fetch_cnt !== 16'hFFFF) begin
            failures++;
            $display("FAIL sat_final got=%h exp=FFFF", fetch_cnt);
        end
    endtask

    initial begin
        exp_cnt = 16'd0;
        test_reset();
        test_single_core();
        test_misaligned();
        test_out_of_range();
        test_deassert_in_flight();
        test_contention();
        test_reset_mid_fetch();
        test_saturation();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
